spi_adc_responder: RTL and testbench

SPI_ADC_RESPONDER -- requirements
Module: spi_adc_responder

---
 rtl/spi_adc_responder.sv | 199 +++++++++++++++++++
 tb/tb_spi_adc_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_responder.sv
// Dual-channel SPI ADC emulator: shifts {zeros, sample} on two MISO lines per CS frame.
// Optional feature macro: SPI_ADC_RESP_PATTERN_EN (internal counting test pattern replaces the sample inputs).
module spi_adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12,
    parameter int LEAD_ZEROS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_ni,
    input  logic              spi_sck_i,
    output logic [1:0]        spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic [DATA_W-1:0] sample0_i,
    input  logic [DATA_W-1:0] sample1_i,
    output logic              sample_load_o,
    output logic              frame_done_o,
    output logic              frame_err_o,
    output logic [15:0]       frame_cnt_o
);

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic                   r_cs_prev;
    logic                   r_sck_prev;
    logic [2:0]             r_settle;
    logic                   r_armed;

    state_t                 r_state;
    logic [FRAME_BITS-1:0]  r_sh0;
    logic [FRAME_BITS-1:0]  r_sh1;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [1:0]             r_miso;
    logic                   r_oe;
    logic                   r_load;
    logic                   r_done;
    logic                   r_err;
    logic [15:0]            r_frame_cnt;

    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sck_fall;
    logic [DATA_W-1:0]      w_samp0;
    logic [DATA_W-1:0]      w_samp1;
    logic [FRAME_BITS-1:0]  w_load0;
    logic [FRAME_BITS-1:0]  w_load1;

    // Synchronizer chains plus one extra flop each for edge detection; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync  <= '1;
            r_sck_sync <= '1;
            r_cs_prev  <= 1'b1;
            r_sck_prev <= 1'b1;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            r_cs_prev  <= r_cs_sync[SYNC_STAGES-1];
            r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    // After reset the chain holds fake idle ones; only accept a CS fall once a genuine high was seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle <= 3'd0;
            r_armed  <= 1'b0;
        end else if (r_settle != 3'(SYNC_STAGES)) begin
            r_settle <= r_settle + 3'd1;
        end else if (r_cs_sync[SYNC_STAGES-1]) begin
            r_armed <= 1'b1;
        end else begin
            r_armed <= r_armed;
        end
    end

    assign w_cs_fall  = r_armed & r_cs_prev & ~r_cs_sync[SYNC_STAGES-1];
    assign w_cs_rise  = ~r_cs_prev & r_cs_sync[SYNC_STAGES-1];
    assign w_sck_fall = r_sck_prev & ~r_sck_sync[SYNC_STAGES-1];

`ifdef SPI_ADC_RESP_PATTERN_EN
    logic [DATA_W-1:0] r_pattern;
    logic              w_unused;

    // Pattern advances once per frame load, so consecutive frames carry 0, 1, 2, ...
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= '0;
        end else if (r_load) begin
            r_pattern <= r_pattern + DATA_W'(1);
        end else begin
            r_pattern <= r_pattern;
        end
    end

    assign w_samp0  = r_pattern;
    assign w_samp1  = ~r_pattern;
    assign w_unused = ^{sample0_i, sample1_i};
`else
    assign w_samp0 = sample0_i;
    assign w_samp1 = sample1_i;
`endif

    assign w_load0 = {{LEAD_ZEROS{1'b0}}, w_samp0};
    assign w_load1 = {{LEAD_ZEROS{1'b0}}, w_samp1};

    // Frame FSM; MISO is registered alongside the shift registers so it always equals the live MSBs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_bit_cnt   <= '0;
            r_miso      <= 2'b00;
            r_oe        <= 1'b0;
            r_load      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_sh0     <= w_load0;
                        r_sh1     <= w_load1;
                        r_bit_cnt <= '0;
                        r_miso    <= {w_load1[FRAME_BITS-1], w_load0[FRAME_BITS-1]};
                        r_oe      <= 1'b1;
                        r_load    <= 1'b1;
                        r_state   <= SHIFT;
                    end else begin
                        r_miso <= 2'b00;
                        r_oe   <= 1'b0;
                    end
                end
                SHIFT: begin
                    // CS rise takes priority: a coincident SCK fall is not counted.
                    if (w_cs_rise) begin
                        r_err     <= 1'b1;
                        r_oe      <= 1'b0;
                        r_miso    <= 2'b00;
                        r_sh0     <= '0;
                        r_sh1     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                    end else if (w_sck_fall) begin
                        r_sh0     <= {r_sh0[FRAME_BITS-2:0], 1'b0};
                        r_sh1     <= {r_sh1[FRAME_BITS-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            r_miso      <= 2'b00;
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_state     <= DONE;
                        end else begin
                            r_miso <= {r_sh1[FRAME_BITS-2], r_sh0[FRAME_BITS-2]};
                        end
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                DONE: begin
                    r_miso <= 2'b00;
                    if (w_cs_rise) begin
                        r_oe    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_miso  <= 2'b00;
                    r_oe    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign spi_miso_o    = r_miso;
    assign spi_miso_oe_o = r_oe;
    assign sample_load_o = r_load;
    assign frame_done_o  = r_done;
    assign frame_err_o   = r_err;
    assign frame_cnt_o   = r_frame_cnt;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: acts as an SPI mode-3 initiator and checks frames and pulses.
module tb_spi_adc_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs_ni;
    logic        spi_sck_i;
    logic [1:0]  spi_miso_o;
    logic        spi_miso_oe_o;
    logic [11:0] sample0_i;
    logic [11:0] sample1_i;
    logic        sample_load_o;
    logic        frame_done_o;
    logic        frame_err_o;
    logic [15:0] frame_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_load   = 0;
    int n_done   = 0;
    int n_err    = 0;

    logic [15:0] rd0, rd1;
    int          l0, d0, e0;

    spi_adc_responder dut (
        .clk           (clk),
        .rst           (rst),
        .spi_cs_ni     (spi_cs_ni),
        .spi_sck_i     (spi_sck_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .sample0_i     (sample0_i),
        .sample1_i     (sample1_i),
        .sample_load_o (sample_load_o),
        .frame_done_o  (frame_done_o),
        .frame_err_o   (frame_err_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (sample_load_o) n_load++;
        if (frame_done_o)  n_done++;
        if (frame_err_o)   n_err++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Lower CS, then read a bit before each of nfalls SCK falling edges; CS stays low afterwards.
    task automatic run_frame(input int nfalls, input int chg_at, input logic [11:0] chg_val,
                             output logic [15:0] r0, output logic [15:0] r1);
        r0 = 16'h0000;
        r1 = 16'h0000;
        spi_cs_ni = 1'b0;
        repeat (HALF) @(negedge clk);
        check_eq("oe_active", {31'd0, spi_miso_oe_o}, 32'd1);
        for (int i = 0; i < nfalls; i++) begin
            if (i == chg_at) sample0_i = chg_val;
            r0 = {r0[14:0], spi_miso_o[0]};
            r1 = {r1[14:0], spi_miso_o[1]};
            spi_sck_i = 1'b0;
            repeat (HALF) @(negedge clk);
            spi_sck_i = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic end_frame();
        spi_cs_ni = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        spi_cs_ni = 1'b1;
        spi_sck_i = 1'b1;
        sample0_i = 12'hA5C;
        sample1_i = 12'h3F1;
        repeat (3) @(negedge clk);
        check_eq("rst_miso", {30'd0, spi_miso_o}, 32'd0);
        check_eq("rst_oe", {31'd0, spi_miso_oe_o}, 32'd0);
        check_eq("rst_cnt", {16'd0, frame_cnt_o}, 32'd0);
        check_eq("rst_pulses", {29'd0, sample_load_o, frame_done_o, frame_err_o}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

`ifdef SPI_ADC_RESP_PATTERN_EN
        for (int f = 0; f < 3; f++) begin
            run_frame(16, -1, 12'h000, rd0, rd1);
            end_frame();
            check_eq("pat_ch0", {16'd0, rd0}, 32'(f));
            check_eq("pat_ch1", {16'd0, rd1}, 32'h0FFF - 32'(f));
        end
        check_eq("pat_cnt", {16'd0, frame_cnt_o}, 32'd3);
`else
        // Full frame
        l0 = n_load; d0 = n_done; e0 = n_err;
        run_frame(16, -1, 12'h000, rd0, rd1);
        check_eq("done_miso0", {30'd0, spi_miso_o}, 32'd0);
        check_eq("done_oe_held", {31'd0, spi_miso_oe_o}, 32'd1);
        end_frame();
        check_eq("f1_ch0", {16'd0, rd0}, 32'h0A5C);
        check_eq("f1_ch1", {16'd0, rd1}, 32'h03F1);
        check_eq("f1_done", 32'(n_done - d0), 32'd1);
        check_eq("f1_err", 32'(n_err - e0), 32'd0);
        check_eq("f1_load", 32'(n_load - l0), 32'd1);
        check_eq("f1_cnt", {16'd0, frame_cnt_o}, 32'd1);
        check_eq("f1_oe_off", {31'd0, spi_miso_oe_o}, 32'd0);

        // SCK toggling while idle is ignored
        l0 = n_load; d0 = n_done;
        for (int i = 0; i < 3; i++) begin
            spi_sck_i = 1'b0;
            repeat (HALF) @(negedge clk);
            spi_sck_i = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        check_eq("idle_miso", {30'd0, spi_miso_o}, 32'd0);
        check_eq("idle_load", 32'(n_load - l0), 32'd0);
        check_eq("idle_done", 32'(n_done - d0), 32'd0);

        // Early CS rise after 9 falls
        e0 = n_err; d0 = n_done;
        run_frame(9, -1, 12'h000, rd0, rd1);
        spi_cs_ni = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("err_oe_off", {31'd0, spi_miso_oe_o}, 32'd0);
        repeat (HALF) @(negedge clk);
        check_eq("err_pulse", 32'(n_err - e0), 32'd1);
        check_eq("err_no_done", 32'(n_done - d0), 32'd0);
        check_eq("err_cnt", {16'd0, frame_cnt_o}, 32'd1);

        // Sample change mid-frame affects only the next frame
        run_frame(16, 5, 12'h123, rd0, rd1);
        end_frame();
        check_eq("chg_cur_ch0", {16'd0, rd0}, 32'h0A5C);
        run_frame(16, -1, 12'h000, rd0, rd1);
        end_frame();
        check_eq("chg_next_ch0", {16'd0, rd0}, 32'h0123);
        check_eq("chg_next_ch1", {16'd0, rd1}, 32'h03F1);
        check_eq("chg_cnt", {16'd0, frame_cnt_o}, 32'd3);

        // CS rise coincident with the 16th SCK fall
        e0 = n_err; d0 = n_done;
        run_frame(15, -1, 12'h000, rd0, rd1);
        spi_cs_ni = 1'b1;
        spi_sck_i = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_sck_i = 1'b1;
        repeat (HALF) @(negedge clk);
        check_eq("tie_err", 32'(n_err - e0), 32'd1);
        check_eq("tie_done", 32'(n_done - d0), 32'd0);
        check_eq("tie_cnt", {16'd0, frame_cnt_o}, 32'd3);

        // Reset mid-frame after 5 falls, CS held low through release
        e0 = n_err;
        run_frame(5, -1, 12'h000, rd0, rd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mrst_miso", {30'd0, spi_miso_o}, 32'd0);
        check_eq("mrst_oe", {31'd0, spi_miso_oe_o}, 32'd0);
        check_eq("mrst_cnt", {16'd0, frame_cnt_o}, 32'd0);
        rst = 1'b0;
        l0 = n_load;
        repeat (10) @(negedge clk);
        check_eq("mrst_no_restart", 32'(n_load - l0), 32'd0);
        check_eq("mrst_oe_stays", {31'd0, spi_miso_oe_o}, 32'd0);
        check_eq("mrst_no_err", 32'(n_err - e0), 32'd0);
        end_frame();
        run_frame(16, -1, 12'h000, rd0, rd1);
        end_frame();
        check_eq("post_ch0", {16'd0, rd0}, 32'h0123);
        check_eq("post_ch1", {16'd0, rd1}, 32'h03F1);
        check_eq("post_cnt", {16'd0, frame_cnt_o}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
